// File: rtl/sccu_fetch_pkg.sv
// Shared definitions for the sccu fetch / next-PC stage: pcsource encodings,
// FSM state encoding, instruction field positions and the default reset PC.
package sccu_fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_JR  = 2'b10,
        PC_J   = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        ISSUE = 2'b10
    } fetch_state_e;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;
    localparam int ADDR_MSB = 25;
    localparam int ADDR_LSB = 0;

    // Sign-extended, word-scaled branch displacement taken from the low instruction field.
    function automatic logic [31:0] br_offset(input logic [ADDR_MSB:ADDR_LSB] addr26);
        return {{14{addr26[IMM_MSB]}}, addr26[IMM_MSB:IMM_LSB], 2'b00};
    endfunction

endpackage

// File: rtl/sccu_npc.sv
// Purely combinational next-PC selection: sequential, branch, register (jr)
// and jump targets, plus a flag for a misaligned jr target.
module sccu_npc
    import sccu_fetch_pkg::*;
(
    input  logic [31:0]            pc,
    input  logic [ADDR_MSB:ADDR_LSB] addr26,
    input  logic [31:0]            rs_data,
    input  logic [1:0]             pcsource,
    output logic [31:0]            pc4,
    output logic [31:0]            next_pc,
    output logic                   jr_misaligned
);

    logic [31:0] pc4_s;

    assign pc4_s = pc + 32'd4;
    assign pc4   = pc4_s;

    // Target mux; jr drops the two low bits and reports if they were set.
    always_comb begin
        next_pc       = pc4_s;
        jr_misaligned = 1'b0;
        case (pcsrc_e'(pcsource))
            PC_SEQ: next_pc = pc4_s;
            PC_BR:  next_pc = pc4_s + br_offset(addr26);
            PC_JR: begin
                next_pc       = {rs_data[31:2], 2'b00};
                jr_misaligned = (rs_data[1:0] != 2'b00);
            end
            PC_J:   next_pc = {pc4_s[31:28], addr26, 2'b00};
            default: next_pc = pc4_s;
        endcase
    end

endmodule

// File: rtl/sccu_fetch.sv
// Instruction fetch and next-PC stage feeding the single-cycle decoder.
// Optional commit counter output enabled with macro SCCU_FETCH_RETIRE_CNT_EN.
module sccu_fetch
    import sccu_fetch_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [1:0]    pcsource,
    input  logic [31:0]   rs_data,
    input  logic          commit,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc4,
    output logic [31:0]   inst,
    output logic [5:0]    op,
    output logic [5:0]    func,
    output logic          inst_valid,
    output logic          addr_err
`ifdef SCCU_FETCH_RETIRE_CNT_EN
   ,output logic [31:0]   retire_cnt
`endif
);

    fetch_state_e  state_r, state_nxt;
    logic [AW-1:0] pc_r, pc_nxt;
    logic [31:0]   inst_r, inst_nxt;
    logic          imem_req_r;
    logic          inst_valid_r;
    logic          addr_err_r;
    logic          accept_s;
    logic [AW-1:0] npc_s;
    logic [AW-1:0] pc4_s;
    logic          jr_mis_s;

    sccu_npc u_npc (
        .pc            (pc_r),
        .addr26        (inst_r[ADDR_MSB:ADDR_LSB]),
        .rs_data       (rs_data),
        .pcsource      (pcsource),
        .pc4           (pc4_s),
        .next_pc       (npc_s),
        .jr_misaligned (jr_mis_s)
    );

    // Next-state logic; ack outside REQ and commit outside ISSUE fall through untouched.
    always_comb begin
        state_nxt = state_r;
        pc_nxt    = pc_r;
        inst_nxt  = inst_r;
        accept_s  = 1'b0;
        case (state_r)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (imem_ack) begin
                    inst_nxt  = imem_rdata;
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = REQ;
                end
            end
            ISSUE: begin
                if (commit) begin
                    pc_nxt    = npc_s;
                    accept_s  = 1'b1;
                    state_nxt = REQ;
                end else begin
                    state_nxt = ISSUE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers; req/valid are registered from the next state.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            inst_r       <= 32'h0000_0000;
            imem_req_r   <= 1'b0;
            inst_valid_r <= 1'b0;
            addr_err_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            pc_r         <= pc_nxt;
            inst_r       <= inst_nxt;
            imem_req_r   <= (state_nxt == REQ);
            inst_valid_r <= (state_nxt == ISSUE);
            addr_err_r   <= accept_s & jr_mis_s;
        end
    end

`ifdef SCCU_FETCH_RETIRE_CNT_EN
    logic [31:0] retire_cnt_r;

    // Count accepted commits; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            retire_cnt_r <= 32'h0000_0000;
        end else if (accept_s) begin
            retire_cnt_r <= retire_cnt_r + 32'd1;
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

    assign retire_cnt = retire_cnt_r;
`endif

    assign imem_req   = imem_req_r;
    assign imem_addr  = pc_r;
    assign pc         = pc_r;
    assign pc4        = pc4_s;
    assign inst       = inst_r;
    assign op         = inst_r[OP_MSB:OP_LSB];
    assign func       = inst_r[FUNC_MSB:FUNC_LSB];
    assign inst_valid = inst_valid_r;
    assign addr_err   = addr_err_r;

endmodule

// File: tb/tb_sccu_fetch.sv
// Directed self-checking bench for sccu_fetch with an address/instruction scoreboard.
module tb_sccu_fetch;

    logic        clk = 1'b0;
    logic        clrn;
    logic [1:0]  pcsource;
    logic [31:0] rs_data;
    logic        commit;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        inst_valid;
    logic        addr_err;
`ifdef SCCU_FETCH_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_commit = 0;
    logic [31:0] addr_q[$];
    logic [31:0] inst_q[$];

    sccu_fetch dut (
        .clk        (clk),
        .clrn       (clrn),
        .pcsource   (pcsource),
        .rs_data    (rs_data),
        .commit     (commit),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .pc4        (pc4),
        .inst       (inst),
        .op         (op),
        .func       (func),
        .inst_valid (inst_valid),
        .addr_err   (addr_err)
`ifdef SCCU_FETCH_RETIRE_CNT_EN
       ,.retire_cnt (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Serve one fetch taking req_cycles cycles in REQ (1 = zero-wait); returns cycles waited for req.
    task automatic fetch(input logic [31:0] rdata, input int req_cycles, output int waited);
        logic [31:0] exp_a;
        logic [31:0] exp_i;
        waited = 0;
        while (!imem_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("req_seen", {31'h0, imem_req}, 32'h1);
        exp_a = (addr_q.size() > 0) ? addr_q.pop_front() : 32'hxxxx_xxxx;
        chk("fetch_addr", imem_addr, exp_a);
        chk("fetch_pc", pc, exp_a);
        for (int k = 1; k < req_cycles; k++) begin
            commit   = 1'b1;
            pcsource = 2'b11;
            @(negedge clk);
            commit = 1'b0;
            chk("req_hold", {31'h0, imem_req}, 32'h1);
            chk("addr_hold", imem_addr, exp_a);
            chk("err_pulse", {31'h0, addr_err}, 32'h0);
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        inst_q.push_back(rdata);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        exp_i = inst_q.pop_front();
        chk("valid", {31'h0, inst_valid}, 32'h1);
        chk("req_off", {31'h0, imem_req}, 32'h0);
        chk("inst", inst, exp_i);
        chk("op", {26'h0, op}, {26'h0, exp_i[31:26]});
        chk("func", {26'h0, func}, {26'h0, exp_i[5:0]});
        chk("pc4", pc4, exp_a + 32'd4);
    endtask

    task automatic do_commit(input logic [1:0] src, input logic [31:0] rs,
                             input logic [31:0] exp_npc, input logic exp_err);
        pcsource = src;
        rs_data  = rs;
        commit   = 1'b1;
        addr_q.push_back(exp_npc);
        n_commit++;
        @(negedge clk);
        commit   = 1'b0;
        pcsource = 2'b00;
        chk("addr_err", {31'h0, addr_err}, {31'h0, exp_err});
        chk("req_after_commit", {31'h0, imem_req}, 32'h1);
        chk("valid_after_commit", {31'h0, inst_valid}, 32'h0);
    endtask

    initial begin
        int w;
        logic [31:0] hold_pc;
        clrn = 1'b0; pcsource = 2'b00; rs_data = 32'h0; commit = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_err", {31'h0, addr_err}, 32'h0);
        chk("rst_op", {26'h0, op}, 32'h0);
`ifdef SCCU_FETCH_RETIRE_CNT_EN
        chk("rst_retire", retire_cnt, 32'h0);
`endif
        clrn = 1'b1;
        addr_q.push_back(32'h0);

        // addi at 0, zero-wait memory: req appears one cycle after IDLE
        fetch(32'h2008_0005, 1, w);
        chk("first_req_latency", w, 32'd1);
        do_commit(2'b00, 32'h0, 32'h4, 1'b0);
        fetch(32'h0000_0000, 1, w);
        do_commit(2'b00, 32'h0, 32'h8, 1'b0);
        fetch(32'h0000_0000, 1, w);
        do_commit(2'b00, 32'h0, 32'hC, 1'b0);
        fetch(32'h0000_0000, 1, w);
        do_commit(2'b00, 32'h0, 32'h10, 1'b0);

        // backward branch, then forward branch from the same pc
        fetch(32'h1000_FFFE, 1, w);
        do_commit(2'b01, 32'h0, 32'hC, 1'b0);
        fetch(32'h0000_0000, 1, w);
        do_commit(2'b00, 32'h0, 32'h10, 1'b0);
        fetch(32'h1000_0003, 1, w);
        do_commit(2'b01, 32'h0, 32'h20, 1'b0);

        // misaligned jr: addr_err high one cycle only (checked low during REQ hold)
        fetch(32'h0060_0008, 1, w);
        do_commit(2'b10, 32'h0000_0103, 32'h100, 1'b1);
        fetch(32'h0060_0008, 2, w);
        do_commit(2'b10, 32'h9000_0000, 32'h9000_0000, 1'b0);

        // jump keeps pc4 top nibble
        fetch(32'h0800_0040, 1, w);
        do_commit(2'b11, 32'h0, 32'h9000_0100, 1'b0);

        // 3-cycle fetch, then ISSUE hold with stray ack and pcsource noise
        fetch(32'h0060_0008, 3, w);
        hold_pc = pc;
        for (int k = 0; k < 5; k++) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            pcsource   = 2'($urandom_range(3, 0));
            @(negedge clk);
            chk("hold_valid", {31'h0, inst_valid}, 32'h1);
            chk("hold_inst", inst, 32'h0060_0008);
            chk("hold_pc", pc, hold_pc);
            chk("hold_req", {31'h0, imem_req}, 32'h0);
        end
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        do_commit(2'b10, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);

        // sequential wrap at the top of the address space
        fetch(32'h0000_0000, 1, w);
        do_commit(2'b00, 32'h0, 32'h0000_0000, 1'b0);
`ifdef SCCU_FETCH_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, n_commit);
`endif

        // reset while in REQ, late ack during IDLE must be ignored
        clrn = 1'b0;
        #1;
        chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_valid", {31'h0, inst_valid}, 32'h0);
        addr_q.delete();
        n_commit = 0;
        @(negedge clk);
        clrn       = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        chk("late_ack_inst", inst, 32'h0);
        chk("late_ack_valid", {31'h0, inst_valid}, 32'h0);
`ifdef SCCU_FETCH_RETIRE_CNT_EN
        chk("retire_after_rst", retire_cnt, 32'h0);
`endif
        addr_q.push_back(32'h0);
        fetch(32'h2008_0005, 1, w);
        do_commit(2'b00, 32'h0, 32'h4, 1'b0);
        fetch(32'h0000_0000, 1, w);
`ifdef SCCU_FETCH_RETIRE_CNT_EN
        chk("retire_one", retire_cnt, n_commit);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sccu_fetch.md
Name: sccu_fetch

Overview:
- Instruction-fetch and next-PC stage directly upstream of the single-cycle control decoder.
- Holds the PC and fetches the instruction word from instruction memory over a req/ack handshake.
- Presents op/func and the full instruction to the decoder, and updates the PC from the decoder's 2-bit pcsource select when the core commits the instruction.
- Fetch is multi-cycle tolerant; execution remains single-cycle once the instruction is issued.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- AW, 32, PC and address width; only 32 is supported.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- clrn  in  1  asynchronous active-low reset
- pcsource  in  2  next-PC select from decoder: 00 pc+4, 01 branch target, 10 register (jr), 11 jump target
- rs_data  in  32  register-file rs value, used for jr
- commit  in  1  core has executed the issued instruction; advance PC
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (word aligned)
- imem_ack  in  1  instruction memory returns data this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- pc  out  32  address of the issued instruction
- pc4  out  32  pc+4, used for the jal link value
- inst  out  32  issued instruction word
- op  out  6  inst[31:26]
- func  out  6  inst[5:0]
- inst_valid  out  1  inst/op/func valid; decoder outputs are meaningful
- addr_err  out  1  one-cycle pulse: jr target was misaligned

Behaviour:
- Reset: asynchronous, active-low. While clrn=0, all state is forced:
  - pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, addr_err=0, state=IDLE.
  - A reset mid-fetch or mid-issue abandons the transaction; a late imem_ack is ignored until the next REQ.
- FSM states: IDLE, REQ, ISSUE.
  - IDLE: entered after reset release; moves to REQ on the next clk.
  - REQ:
    - imem_req=1 and imem_addr=pc, both held stable until ack.
    - On imem_ack=1, inst<=imem_rdata and go to ISSUE. A zero-wait memory may ack in the first REQ cycle, giving a 1-cycle fetch.
  - ISSUE:
    - inst_valid=1 and imem_req=0.
    - On commit=1, pc<=next_pc and go to REQ.
    - Without commit, hold indefinitely; inst stays stable.
- Ignored inputs: commit outside ISSUE, and imem_ack outside REQ.
- Issue-to-next-request latency: 1 cycle (commit edge, then REQ).
- next_pc, combinational from registered inst and pc:
  - 00: pc4.
  - 01: pc4 + {{14{inst[15]}}, inst[15:0], 2'b00}.
  - 10: {rs_data[31:2], 2'b00}. If rs_data[1:0]!=0, pulse addr_err for the commit cycle+1.
  - 11: {pc4[31:28], inst[25:0], 2'b00}.
- Arithmetic is modulo 2^32. pc=32'hFFFF_FFFC with pcsource 00 gives 32'h0000_0000; there is no overflow flag.
- op and func are always slices of inst. With inst_valid=0 they show the last instruction (0 after reset).
- Simultaneous commit and a pcsource change in the same cycle: the value sampled at the commit edge is used.

Optional Feature:
- Macro: SCCU_FETCH_RETIRE_CNT_EN.
- When defined:
  - Extra output retire_cnt, out, 32: counts commits accepted in ISSUE.
  - Reset value 0; wraps from 32'hFFFF_FFFF to 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package:
  - pcsource encodings PC_SEQ=2'b00, PC_BR=2'b01, PC_JR=2'b10, PC_J=2'b11.
  - FSM state encoding.
  - Instruction field bit positions (op, func, imm16, addr26).
  - Default RESET_PC.
- One natural sub-module: sccu_npc, the purely combinational next-PC mux and adders, reusable by a later pipelined core.

Test Plan:
- Reset then zero-wait memory returning 32'h2008_0005 (addi) → imem_addr=0 and inst_valid on the 2nd cycle after IDLE, op=6'h08; commit with pcsource=00 → next imem_addr=32'h4.
- Branch at pc=32'h10, inst=32'h1000_FFFE, pcsource=01 → next pc=32'h0C; with imm=16'h0003 → pc=32'h20.
- jr with rs_data=32'h0000_0103, pcsource=10 → pc=32'h100, addr_err pulses exactly 1 cycle.
- j at pc=32'h9000_0000, inst=32'h0800_0040, pcsource=11 → pc=32'h9000_0100.
- Memory with 3-cycle ack delay, commit held low 5 cycles in ISSUE → imem_req high 3 cycles with stable address, inst stable, pc unchanged until commit.
- Assert clrn=0 during REQ, then ack arrives after release → ack ignored, pc=RESET_PC; with the macro defined, retire_cnt=0 and it increments once per commit.
